sdf_delay_line: RTL

- Parametrised complex (re/im) feedback delay line for radix-2 single-path delay-feedback (SDF) FFT stages.
- Delay depth is runtime-selectable as a power of two up to MAX_DEPTH, so one block serves every stage and every FFT size.
- Shifts only on valid input beats, so the pipeline can stall.
- Generates the fill/butterfly phase bit that the stage butterfly mux consumes.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/sdf_delay_ctrl.sv | 74 +++++++
 rtl/sdf_delay_line.sv | 81 ++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the SDF FFT datapath.
package fft_pkg;

   localparam int unsigned DATA_DEF     = 9;
   localparam int unsigned MAX_LOG2_DEF = 4;

   typedef struct packed {
      logic signed [DATA_DEF-1:0] re;
      logic signed [DATA_DEF-1:0] im;
   } cplx_t;

   // Active delay for a select value, clamped to the physical chain length.
   function automatic int unsigned depth_of(input int unsigned sel,
                                            input int unsigned max_log2 = MAX_LOG2_DEF);
      if (sel > max_log2) begin
         return 32'd1 << max_log2;
      end
      return 32'd1 << sel;
   endfunction

endpackage

// File: rtl/sdf_delay_ctrl.sv
// Control for the SDF delay line: active depth, fill and block counters,
// and the fill/butterfly phase bit.
module sdf_delay_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF,
   parameter int unsigned SEL_W    = $clog2(MAX_LOG2 + 1)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                clr,
   input  logic [SEL_W-1:0]    depth_sel,
   input  logic                in_valid,
   output logic                out_valid,
   output logic                phase,
   output logic [MAX_LOG2-1:0] tap_idx,
   output logic                shift_en
);

   localparam int unsigned      CntW   = MAX_LOG2 + 1;
   localparam logic [SEL_W-1:0] MaxSel = SEL_W'(MAX_LOG2);

   logic [SEL_W-1:0]    sel_clamped;
   logic [SEL_W-1:0]    cur_sel_d, cur_sel_q;
   logic [CntW-1:0]     fill_d, fill_q;
   logic [CntW-1:0]     depth;
   logic [MAX_LOG2-1:0] blk_d, blk_q;
   logic                phase_d, phase_q;

   assign sel_clamped = (depth_sel > MaxSel) ? MaxSel : depth_sel;
   assign depth       = CntW'(depth_of(32'(cur_sel_q), MAX_LOG2));
   assign tap_idx     = MAX_LOG2'(depth - CntW'(1));
   assign out_valid   = (fill_q == depth);
   assign phase       = phase_q;
   assign shift_en    = in_valid & ~clr;

   always_comb begin
      cur_sel_d = sel_clamped;
      fill_d    = fill_q;
      blk_d     = blk_q;
      phase_d   = phase_q;
      // A depth change restarts counting; a beat in that cycle shifts but is not counted.
      if (clr || (sel_clamped != cur_sel_q)) begin
         fill_d  = '0;
         blk_d   = '0;
         phase_d = 1'b0;
      end else if (in_valid) begin
         if (fill_q != depth) begin
            fill_d = fill_q + CntW'(1);
         end
         if (blk_q == tap_idx) begin
            blk_d   = '0;
            phase_d = ~phase_q;
         end else begin
            blk_d = blk_q + MAX_LOG2'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cur_sel_q <= '0;
         fill_q    <= '0;
         blk_q     <= '0;
         phase_q   <= 1'b0;
      end else begin
         cur_sel_q <= cur_sel_d;
         fill_q    <= fill_d;
         blk_q     <= blk_d;
         phase_q   <= phase_d;
      end
   end

endmodule

// File: rtl/sdf_delay_line.sv
// Complex feedback delay line for radix-2 SDF FFT stages with a runtime
// power-of-two depth and stall-tolerant shifting.
module sdf_delay_line
   import fft_pkg::*;
#(
   parameter int unsigned DATA     = DATA_DEF,
   parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF,
   parameter int unsigned SEL_W    = $clog2(MAX_LOG2 + 1)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clr,
   input  logic [SEL_W-1:0]       depth_sel,
   input  logic                   in_valid,
   input  logic signed [DATA-1:0] data_in_re,
   input  logic signed [DATA-1:0] data_in_im,
   output logic signed [DATA-1:0] data_out_re,
   output logic signed [DATA-1:0] data_out_im,
   output logic                   out_valid,
   output logic                   phase
);

   localparam int unsigned MaxDepth = 1 << MAX_LOG2;

   logic signed [DATA-1:0] re_d [MaxDepth];
   logic signed [DATA-1:0] re_q [MaxDepth];
   logic signed [DATA-1:0] im_d [MaxDepth];
   logic signed [DATA-1:0] im_q [MaxDepth];
   logic [MAX_LOG2-1:0]    tap_idx;
   logic                   shift_en;

   sdf_delay_ctrl #(
      .MAX_LOG2 (MAX_LOG2),
      .SEL_W    (SEL_W)
   ) u_ctrl (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr),
      .depth_sel (depth_sel),
      .in_valid  (in_valid),
      .out_valid (out_valid),
      .phase     (phase),
      .tap_idx   (tap_idx),
      .shift_en  (shift_en)
   );

   // The chain is always full length; depth only moves the output tap.
   always_comb begin
      re_d = re_q;
      im_d = im_q;
      if (clr) begin
         for (int i = 0; i < MaxDepth; i++) begin
            re_d[i] = '0;
            im_d[i] = '0;
         end
      end else if (shift_en) begin
         re_d[0] = data_in_re;
         im_d[0] = data_in_im;
         for (int i = 1; i < MaxDepth; i++) begin
            re_d[i] = re_q[i-1];
            im_d[i] = im_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < MaxDepth; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else begin
         re_q <= re_d;
         im_q <= im_d;
      end
   end

   assign data_out_re = re_q[tap_idx];
   assign data_out_im = im_q[tap_idx];

endmodule
